// File: rtl/tt_keypad_scan_if.sv
// Keypad scanner signal bundle.
//  row_in    : keypad rows, active-low, asynchronous to clk
//  col_out   : active-low one-hot column drive
//  key_4     : debounced key code (row*4 + col)
//  pulse     : one-clk strobe per debounced new press
//  key_valid : high while a debounced key is held
// Modports: slave = the scanner, master = keypad/consumer side.
interface tt_keypad_scan_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_4;
    logic       pulse;
    logic       key_valid;

    modport master (
        output row_in,
        input  col_out,
        input  key_4,
        input  pulse,
        input  key_valid
    );

    modport slave (
        input  row_in,
        output col_out,
        output key_4,
        output pulse,
        output key_valid
    );
endinterface

// File: rtl/tt_keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Ports:
//  clk : system clock, rising edge
//  rst : asynchronous active-high reset
//  kp  : tt_keypad_scan_if.slave (row_in in; col_out, key_4, pulse, key_valid out)
module tt_keypad_scan #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic            clk,
    input  logic            rst,
    tt_keypad_scan_if.slave kp
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned MW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [3:0]    cand;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] rel_cnt;
    logic [3:0]    col_out_q;
    logic [3:0]    key_4_q;
    logic          pulse_q;
    logic          key_valid_q;

    logic          sample;
    logic          row_hit;
    logic [1:0]    win_row;
    logic [3:0]    win_code;
    logic [1:0]    next_col;

    assign kp.col_out   = col_out_q;
    assign kp.key_4     = key_4_q;
    assign kp.pulse     = pulse_q;
    assign kp.key_valid = key_valid_q;

    // Lowest active row wins; loop runs high-to-low so the last hit is the lowest index.
    always_comb begin
        row_hit = 1'b0;
        win_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_s[r]) begin
                row_hit = 1'b1;
                win_row = 2'(r);
            end
        end
    end

    assign sample   = (dwell == DWELL_LAST);
    assign win_code = {win_row, col_idx};
    assign next_col = col_idx + 2'd1;

    // Synchroniser, dwell timer and scan/debounce FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SCAN;
            rows_m      <= 4'hF;
            rows_s      <= 4'hF;
            dwell       <= '0;
            col_idx     <= 2'd0;
            cand        <= 4'd0;
            match_cnt   <= '0;
            rel_cnt     <= '0;
            col_out_q   <= 4'b1110;
            key_4_q     <= 4'd0;
            pulse_q     <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            rows_m  <= kp.row_in;
            rows_s  <= rows_m;
            // Dwell free-runs; every column change happens on a sample, so it also restarts here.
            dwell   <= sample ? '0 : dwell + DW'(1);

            if (sample) begin
                case (state)
                    SCAN: begin
                        if (!row_hit) begin
                            col_idx   <= next_col;
                            col_out_q <= ~(4'(1) << next_col);
                        end else begin
                            cand      <= win_code;
                            match_cnt <= MW'(1);
                            state     <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_hit && (win_code == cand)) begin
                            // Compare against DEBOUNCE_CNT-1 so the counter never has to hold DEBOUNCE_CNT.
                            if (match_cnt == MATCH_LAST) begin
                                key_4_q     <= cand;
                                pulse_q     <= 1'b1;
                                key_valid_q <= 1'b1;
                                match_cnt   <= '0;
                                rel_cnt     <= '0;
                                state       <= PRESSED;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                            col_idx   <= next_col;
                            col_out_q <= ~(4'(1) << next_col);
                            state     <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (!row_hit) begin
                            if (rel_cnt == MATCH_LAST) begin
                                key_valid_q <= 1'b0;
                                rel_cnt     <= '0;
                                col_idx     <= next_col;
                                col_out_q   <= ~(4'(1) << next_col);
                                state       <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + MW'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_keypad_scan.sv
// Directed testbench for tt_keypad_scan (SCAN_DIV=16, DEBOUNCE_CNT=4).
// A keypad model pulls a row low whenever a pressed key sits in the driven column.
module tb_tt_keypad_scan;

    logic        clk;
    logic        rst;
    logic [15:0] keys;
    int          ecount;
    int          pulse_cnt;
    int          passed;
    int          failed;
    int          total;

    tt_keypad_scan_if kp ();

    tt_keypad_scan #(.SCAN_DIV(16), .DEBOUNCE_CNT(4)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: key index = row*4 + col.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            kp.row_in[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && (kp.col_out[c] === 1'b0)) kp.row_in[r] = 1'b0;
            end
        end
    end

    // Each pulse is one clk wide, so one sample per cycle counts each once.
    always @(negedge clk) begin
        if (kp.pulse === 1'b1) pulse_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ecount++;
        end
    endtask

    task automatic wait_pulse(input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (kp.pulse === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_release(input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (kp.key_valid === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        passed    = 0;
        failed    = 0;
        total     = 0;
        pulse_cnt = 0;
        ecount    = 0;
        keys      = 16'h0000;
        rst       = 1'b1;

        // 1. Reset values and column rotation.
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_out", 32'(kp.col_out), 32'hE);
        check("rst_key_4", 32'(kp.key_4), 32'h0);
        check("rst_pulse", 32'(kp.pulse), 32'h0);
        check("rst_key_valid", 32'(kp.key_valid), 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        ecount = 0;
        step(15);
        check("rot_hold_col0", 32'(kp.col_out), 32'hE);
        step(1);
        check("rot_col1", 32'(kp.col_out), 32'hD);
        step(16);
        check("rot_col2", 32'(kp.col_out), 32'hB);
        step(16);
        check("rot_col3", 32'(kp.col_out), 32'h7);
        step(16);
        check("rot_wrap_col0", 32'(kp.col_out), 32'hE);

        // 2. Key 9 (row2,col1): col1 driven from edge 80, detect at 96, pulse after edge 144.
        keys[9] = 1'b1;
        step(16);
        check("k9_col1_driven", 32'(kp.col_out), 32'hD);
        step(63);
        check("k9_no_early_pulse", 32'(kp.pulse), 32'h0);
        check("k9_not_valid_yet", 32'(kp.key_valid), 32'h0);
        step(1);
        check("k9_pulse", 32'(kp.pulse), 32'h1);
        check("k9_key_4", 32'(kp.key_4), 32'h9);
        check("k9_key_valid", 32'(kp.key_valid), 32'h1);
        step(1);
        check("k9_pulse_one_clk", 32'(kp.pulse), 32'h0);
        check("k9_col_held", 32'(kp.col_out), 32'hD);
        keys = 16'h0000;
        // Release samples at 160..208; scanning then resumes at col2, col3 from 224.
        step(224 - ecount);

        // 3. Bounce on key 3 (row0,col3) for 20 clks.
        check("bnc_col3", 32'(kp.col_out), 32'h7);
        keys[3] = 1'b1;
        step(20);
        check("bnc_col_held", 32'(kp.col_out), 32'h7);
        keys = 16'h0000;
        step(256 - ecount);
        check("bnc_resume_col0", 32'(kp.col_out), 32'hE);
        check("bnc_no_valid", 32'(kp.key_valid), 32'h0);
        check("bnc_no_pulse", 32'(pulse_cnt), 32'd1);

        // 4. Long hold of key 5 then release.
        keys[5] = 1'b1;
        wait_pulse(200, "k5_pulse_seen");
        check("k5_key_4", 32'(kp.key_4), 32'h5);
        step(2000);
        while ((ecount % 16) != 4) step(1);
        keys = 16'h0000;
        // First all-high sample 12 edges later; key_valid falls 48 edges after it.
        step(12 + 47);
        check("k5_still_valid", 32'(kp.key_valid), 32'h1);
        check("k5_single_pulse", 32'(pulse_cnt), 32'd2);
        step(1);
        check("k5_released", 32'(kp.key_valid), 32'h0);
        check("k5_key_4_kept", 32'(kp.key_4), 32'h5);
        check("k5_next_col2", 32'(kp.col_out), 32'hB);

        // 5. Rows 1 and 3 in col2; then key 15 while held.
        keys[6]  = 1'b1;
        keys[14] = 1'b1;
        wait_pulse(200, "k6_pulse_seen");
        check("k6_lowest_row", 32'(kp.key_4), 32'h6);
        keys[15] = 1'b1;
        step(200);
        check("k15_ignored_pulse", 32'(pulse_cnt), 32'd3);
        check("k15_ignored_key_4", 32'(kp.key_4), 32'h6);
        check("k15_still_valid", 32'(kp.key_valid), 32'h1);
        keys = 16'h0000;
        wait_release(200, "k6_release_seen");

        // 6. Reset in DEBOUNCE with match_cnt=3, then a fresh debounce.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        ecount = 0;
        keys[4] = 1'b1;
        step(50);
        check("rd_no_pulse_yet", 32'(kp.pulse), 32'h0);
        rst = 1'b1;
        #1;
        check("rd_col_out", 32'(kp.col_out), 32'hE);
        check("rd_key_4", 32'(kp.key_4), 32'h0);
        check("rd_pulse", 32'(kp.pulse), 32'h0);
        check("rd_key_valid", 32'(kp.key_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        ecount = 0;
        step(63);
        check("rd_full_debounce", 32'(pulse_cnt), 32'd3);
        check("rd_no_early_pulse", 32'(kp.pulse), 32'h0);
        step(1);
        check("rd_pulse", 32'(kp.pulse), 32'h1);
        check("rd_key_4_new", 32'(kp.key_4), 32'h4);
        check("rd_key_valid_new", 32'(kp.key_valid), 32'h1);
        keys = 16'h0000;
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
